// File: rtl/vga_text_pkg.sv
// Shared types and constants for the text-screen character write path.
// Issue FSM encoding, character width and default FIFO depth.
package vga_text_pkg;

   localparam int CHAR_W          = 7;
   localparam int CHAR_FIFO_DEPTH = 16;
   localparam int OVF_W           = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GUARD = 2'd2,
      WAIT  = 2'd3
   } issue_st_t;

   // Saturating increment used by the dropped-write counter.
   function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
      return (v == {OVF_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/char_fifo_mem.sv
// DEPTH x CHAR_W character queue with registered pointers, flags and level.
// The caller guarantees push is only raised when there is room (or a pop frees it).
module char_fifo_mem
   import vga_text_pkg::*;
#(
   parameter int DEPTH = CHAR_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              push,
   input  logic [CHAR_W-1:0] push_data,
   input  logic              pop,
   output logic [CHAR_W-1:0] pop_data,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       level
);

   logic [CHAR_W-1:0] mem [DEPTH];
   logic [AW:0]       wptr;
   logic [AW:0]       rptr;
   logic [AW:0]       wptr_nxt;
   logic [AW:0]       rptr_nxt;
   logic [AW:0]       level_nxt;

   assign pop_data = mem[rptr[AW-1:0]];

   // Pointers carry one extra bit so the difference distinguishes full from empty.
   always_comb begin
      wptr_nxt  = wptr + {{AW{1'b0}}, push};
      rptr_nxt  = rptr + {{AW{1'b0}}, pop};
      level_nxt = wptr_nxt - rptr_nxt;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         wptr  <= wptr_nxt;
         rptr  <= rptr_nxt;
         level <= level_nxt;
         full  <= (level_nxt == (AW+1)'(DEPTH));
         empty <= (level_nxt == '0);
      end
   end

   always_ff @(posedge HCLK) begin
      if (push) begin
         mem[wptr[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/vga_char_fifo.sv
// Character write buffer between the AHB text write path and the tile-memory port.
// Define VGA_CHAR_FIFO_OVF_EN to enable the saturating dropped-write counter.
module vga_char_fifo
   import vga_text_pkg::*;
#(
   parameter  int DEPTH = CHAR_FIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              wr_en,
   input  logic [CHAR_W-1:0] wr_data,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       level,
   output logic              gen_wen,
   output logic [CHAR_W-1:0] gen_din,
   input  logic              gen_busy,
   output logic [OVF_W-1:0]  ovf_count,
   output issue_st_t         dbg_state
);

   // Handshake: a write is accepted when wr_en is high and the queue is not full,
   // or when it is full but the head is popped on the same edge. gen_wen is a
   // single-cycle pulse; the generator acknowledges only via gen_busy.

   issue_st_t         state;
   issue_st_t         state_nxt;
   logic              pop;
   logic              push;
   logic [CHAR_W-1:0] pop_data;

   assign push      = wr_en & (~full | pop);
   assign dbg_state = state;

   char_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .push      (push),
      .push_data (wr_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // GUARD gives the generator one cycle to raise busy before WAIT samples it.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      gen_wen   = 1'b0;
      case (state)
         IDLE: begin
            if (~empty & ~gen_busy) begin
               state_nxt = ISSUE;
               pop       = 1'b1;
            end
         end
         ISSUE: begin
            gen_wen   = 1'b1;
            state_nxt = GUARD;
         end
         GUARD: begin
            state_nxt = WAIT;
         end
         WAIT: begin
            if (~gen_busy) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         gen_din <= '0;
      end else if (pop) begin
         gen_din <= pop_data;
      end
   end

`ifdef VGA_CHAR_FIFO_OVF_EN
   logic drop;

   assign drop = wr_en & full & ~pop;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ovf_count <= '0;
      end else if (drop) begin
         ovf_count <= sat_inc(ovf_count);
      end
   end
`else
   assign ovf_count = '0;
`endif

   a_wen_single : assert property (@(posedge HCLK) disable iff (!HRESETn)
      gen_wen |=> !gen_wen);

   a_level_bound : assert property (@(posedge HCLK) disable iff (!HRESETn)
      level <= (AW+1)'(DEPTH));

endmodule

// File: tb/tb_vga_char_fifo.sv
// Randomised scoreboard bench for vga_char_fifo against a queue-based reference model.
// Honours VGA_CHAR_FIFO_OVF_EN in the model the same way the design does.
module tb_vga_char_fifo;
   import vga_text_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic       HCLK     = 1'b0;
   logic       HRESETn  = 1'b0;
   logic       wr_en    = 1'b0;
   logic [6:0] wr_data  = '0;
   logic       gen_busy = 1'b0;
   logic       full;
   logic       empty;
   logic [AW:0] level;
   logic       gen_wen;
   logic [6:0] gen_din;
   logic [7:0] ovf_count;
   issue_st_t  dbg_state;

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- clock / reset ----------------
   always #5 HCLK = ~HCLK;

   vga_char_fifo #(.DEPTH(DEPTH)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .gen_wen   (gen_wen),
      .gen_din   (gen_din),
      .gen_busy  (gen_busy),
      .ovf_count (ovf_count),
      .dbg_state (dbg_state)
   );

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Occupancy is a plain queue. The issue engine is described by timestamps:
   // after a pulse it cannot issue again until it has seen busy low on some edge
   // at least three edges after the pop.
   logic [6:0] m_q[$];
   logic [6:0] exp_q[$];
   int         exp_t[$];
   logic [6:0] m_din     = '0;
   int         m_ovf     = 0;
   bit         eng_ready = 1'b1;
   int         pop_edge  = 0;
   int         ecnt      = 0;

   always @(posedge HCLK) begin
      bit m_pop;
      bit m_acc;
      ecnt++;
      if (!HRESETn) begin
         m_q.delete();
         exp_q.delete();
         exp_t.delete();
         m_din     = '0;
         m_ovf     = 0;
         eng_ready = 1'b1;
      end else begin
         m_pop = (m_q.size() != 0) && !gen_busy && eng_ready;
         if (!eng_ready && (ecnt >= pop_edge + 3) && !gen_busy) eng_ready = 1'b1;
         m_acc = wr_en && ((m_q.size() < DEPTH) || m_pop);
         if (m_pop) begin
            m_din     = m_q.pop_front();
            eng_ready = 1'b0;
            pop_edge  = ecnt;
            exp_q.push_back(m_din);
            exp_t.push_back(ecnt);
         end
         if (m_acc) m_q.push_back(wr_data);
`ifdef VGA_CHAR_FIFO_OVF_EN
         if (wr_en && !m_acc && m_ovf < 255) m_ovf++;
`endif
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge HCLK) begin
      bit want;
      want = (exp_t.size() != 0) && (exp_t[0] == ecnt);
      chk("gen_wen", int'(gen_wen), int'(want));
      if (want) begin
         chk("pulse_char", int'(gen_din), int'(exp_q[0]));
         void'(exp_t.pop_front());
         void'(exp_q.pop_front());
      end
      chk("gen_din_hold", int'(gen_din), int'(m_din));
      chk("level", int'(level), m_q.size());
      chk("full", int'(full), int'(m_q.size() == DEPTH));
      chk("empty", int'(empty), int'(m_q.size() == 0));
      chk("ovf_count", int'(ovf_count), m_ovf);
   end

   // ---------------- driver ----------------
   task automatic drive(input bit we, input logic [6:0] d, input bit busy);
      wr_en    = we;
      wr_data  = d;
      gen_busy = busy;
      @(negedge HCLK);
      #1;
   endtask

   initial begin
      int  run;
      bit  rbusy;
      @(negedge HCLK);
      #1;
      repeat (2) drive(1'b0, 7'h00, 1'b0);
      HRESETn = 1'b1;

      // single character through an idle generator
      drive(1'b1, 7'h41, 1'b0);
      repeat (8) drive(1'b0, 7'h00, 1'b0);

      // fill while busy, overflow, then pop coinciding with a push into a full queue
      for (int i = 0; i < 16; i++) drive(1'b1, 7'(8'h30 + i), 1'b1);
      for (int i = 0; i < 3; i++) drive(1'b1, 7'(8'h60 + i), 1'b1);
      drive(1'b1, 7'h5A, 1'b0);
      repeat (80) drive(1'b0, 7'h00, 1'b0);

      // busy raised during GUARD and held for 10 cycles
      drive(1'b1, 7'h11, 1'b0);
      drive(1'b0, 7'h00, 1'b0);
      drive(1'b0, 7'h00, 1'b0);
      drive(1'b1, 7'h12, 1'b1);
      chk("state_wait_entry", int'(dbg_state), int'(WAIT));
      repeat (9) drive(1'b0, 7'h00, 1'b1);
      chk("state_wait_held", int'(dbg_state), int'(WAIT));
      repeat (10) drive(1'b0, 7'h00, 1'b0);

      // long overflow run to exercise saturation
      for (int i = 0; i < 16; i++) drive(1'b1, 7'($urandom_range(0, 127)), 1'b1);
      repeat (260) drive(1'b1, 7'($urandom_range(0, 127)), 1'b1);
      repeat (80) drive(1'b0, 7'h00, 1'b0);

      // randomised traffic with busy in runs
      run   = 0;
      rbusy = 1'b0;
      repeat (1500) begin
         if (run == 0) begin
            rbusy = ($urandom_range(0, 2) == 0);
            run   = $urandom_range(1, 12);
         end
         run--;
         drive(bit'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), rbusy);
      end
      repeat (80) drive(1'b0, 7'h00, 1'b0);

      // reset while in WAIT with five entries queued
      drive(1'b1, 7'h70, 1'b0);
      drive(1'b1, 7'h71, 1'b0);
      drive(1'b1, 7'h72, 1'b0);
      drive(1'b1, 7'h73, 1'b1);
      drive(1'b1, 7'h74, 1'b1);
      drive(1'b1, 7'h75, 1'b1);
      chk("pre_reset_level", int'(level), 5);
      HRESETn = 1'b0;
      drive(1'b0, 7'h00, 1'b1);
      drive(1'b0, 7'h00, 1'b0);
      HRESETn = 1'b1;
      chk("post_reset_state", int'(dbg_state), int'(IDLE));
      repeat (20) drive(1'b0, 7'h00, 1'b0);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
